// File: rtl/adder_tb_pkg.sv
// Shared types and widths for the adder launch/capture stage.
//   alc_state_t : launch/capture FSM states
//   ERR_W       : width of the saturating mismatch counter
//   SETTLE_W    : width of the settle down-counter
package adder_tb_pkg;

  localparam int unsigned ERR_W    = 16;
  localparam int unsigned SETTLE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } alc_state_t;

endpackage

// File: rtl/adder_launch_capture_settle_counter.sv
// Settle-time down-counter for the launch/capture stage.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one
//   zero       : counter currently holds zero
module settle_counter
  import adder_tb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt;

  // Count register; the caller only decrements while nonzero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - SETTLE_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/adder_launch_capture.sv
// Launch/capture register stage around a combinational N-bit adder.
// Operands accepted on in_valid/in_ready are registered onto dut_a/dut_b/dut_cin,
// the adder is given SETTLE cycles to settle, then dut_sum/dut_cout are
// captured, checked against a behavioural A+B+Cin and offered on
// out_valid/out_ready together with mismatch statistics.
//   clk, rst_n                     : clock, async active-low reset
//   en                             : allow new operand accepts
//   err_clr                        : clear err_count / err_sticky
//   in_valid/in_ready/in_a/in_b/in_cin : operand handshake
//   dut_a/dut_b/dut_cin            : registered operands to the adder
//   dut_sum/dut_cout               : adder outputs
//   out_valid/out_ready/out_sum/out_cout/out_mismatch : result handshake
//   err_count/err_sticky           : mismatch statistics
module adder_launch_capture
  import adder_tb_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned SETTLE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             err_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_cin,
  output logic [N-1:0]     dut_a,
  output logic [N-1:0]     dut_b,
  output logic             dut_cin,
  input  logic [N-1:0]     dut_sum,
  input  logic             dut_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_cout,
  output logic             out_mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sticky
);

  // The SETTLE parameter shadows the state name, so states are package-scoped.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  alc_state_t state;
  logic       accept;
  logic       capture;
  logic       cnt_zero;
  logic       cnt_dec;
  logic [N:0] ref_sum;
  logic       mismatch_c;

  // in_ready depends only on state and en.
  assign in_ready = (state == adder_tb_pkg::IDLE) && en;
  assign accept   = in_valid && in_ready;
  assign cnt_dec  = (state == adder_tb_pkg::SETTLE) && !cnt_zero;
  assign capture  = (state == adder_tb_pkg::SETTLE) && cnt_zero;

  // Reference sum kept at N+1 bits so the carry is compared too.
  assign ref_sum    = {1'b0, dut_a} + {1'b0, dut_b} + (N+1)'(dut_cin);
  assign mismatch_c = ({dut_cout, dut_sum} != ref_sum);

  settle_counter u_settle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // FSM, operand launch registers and result capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= adder_tb_pkg::IDLE;
      dut_a        <= '0;
      dut_b        <= '0;
      dut_cin      <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_cout     <= 1'b0;
      out_mismatch <= 1'b0;
    end else begin
      case (state)
        adder_tb_pkg::IDLE: begin
          if (accept) begin
            dut_a   <= in_a;
            dut_b   <= in_b;
            dut_cin <= in_cin;
            state   <= adder_tb_pkg::SETTLE;
          end
        end
        adder_tb_pkg::SETTLE: begin
          if (capture) begin
            out_sum      <= dut_sum;
            out_cout     <= dut_cout;
            out_mismatch <= mismatch_c;
            out_valid    <= 1'b1;
            state        <= adder_tb_pkg::HOLD;
          end
        end
        adder_tb_pkg::HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= adder_tb_pkg::IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= adder_tb_pkg::IDLE;
        end
      endcase
    end
  end

  // Mismatch statistics; a clear wins over a same-cycle mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (err_clr) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (capture && mismatch_c) begin
      err_sticky <= 1'b1;
      if (err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_launch_capture.sv
// Self-checking bench for adder_launch_capture with a behavioural adder
// (optionally faulty: sum forced to zero) and a result scoreboard.
module tb_adder_launch_capture;

  localparam int unsigned N      = 16;
  localparam int unsigned SETTLE = 3;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         mis;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          err_clr;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          in_cin;
  logic [N-1:0]  dut_a;
  logic [N-1:0]  dut_b;
  logic          dut_cin;
  logic [N-1:0]  dut_sum;
  logic          dut_cout;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_cout;
  logic          out_mismatch;
  logic [15:0]   err_count;
  logic          err_sticky;

  logic          fault;
  logic [N:0]    true_sum;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  adder_launch_capture #(.N(N), .SETTLE(SETTLE)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .err_clr      (err_clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_cin       (in_cin),
    .dut_a        (dut_a),
    .dut_b        (dut_b),
    .dut_cin      (dut_cin),
    .dut_sum      (dut_sum),
    .dut_cout     (dut_cout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_cout     (out_cout),
    .out_mismatch (out_mismatch),
    .err_count    (err_count),
    .err_sticky   (err_sticky)
  );

  // Adder under test: correct, or with the sum stuck at zero.
  assign true_sum = {1'b0, dut_a} + {1'b0, dut_b} + 17'(dut_cin);
  assign dut_sum  = fault ? '0 : true_sum[N-1:0];
  assign dut_cout = true_sum[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic flt);
    exp_t       e;
    logic [N:0] t;
    logic [N:0] got;
    t      = {1'b0, a} + {1'b0, b} + 17'(cin);
    got    = flt ? {t[N], 16'h0000} : t;
    e.sum  = got[N-1:0];
    e.cout = got[N];
    e.mis  = (got != t);
    return e;
  endfunction

  // Present one operand set, accept it, return at the negedge after the accept edge.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    sb.push_back(model(a, b, cin, fault));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("dut_a_launch", 32'(dut_a), 32'(a));
    check("dut_b_launch", 32'(dut_b), 32'(b));
  endtask

  // Bounded wait for out_valid; latency counted in edges after the accept edge.
  task automatic wait_valid();
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(SETTLE));
  endtask

  task automatic compare_out();
    exp_t e;
    check("sb_size", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("out_sum", 32'(out_sum), 32'(e.sum));
      check("out_cout", 32'(out_cout), 32'(e.cout));
      check("out_mismatch", 32'(out_mismatch), 32'(e.mis));
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int   accepted;
    int   delivered;
    int   cyc;
    int   last_del;
    logic [N-1:0] held_sum;

    rst_n     = 1'b0;
    en        = 1'b1;
    err_clr   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    fault     = 1'b0;

    // Reset values
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dut_a", 32'(dut_a), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic add and latency
    launch(16'h1234, 16'h4321, 1'b0);
    wait_valid();
    compare_out();
    handshake();

    // Carry boundaries
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_valid();
    compare_out();
    handshake();
    launch(16'hFFFF, 16'hFFFF, 1'b1);
    wait_valid();
    compare_out();
    handshake();

    // Faulty adder: mismatch counting, then clear colliding with a mismatch capture
    fault = 1'b1;
    launch(16'd5, 16'd7, 1'b0);
    wait_valid();
    compare_out();
    check("err_count_one", 32'(err_count), 32'd1);
    check("err_sticky_set", 32'(err_sticky), 32'd1);
    handshake();
    launch(16'd9, 16'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_out_valid", 32'(out_valid), 32'd1);
    check("clr_err_count", 32'(err_count), 32'd0);
    check("clr_err_sticky", 32'(err_sticky), 32'd0);
    compare_out();
    handshake();
    fault = 1'b0;

    // Output back-pressure
    launch(16'h0F0F, 16'h1010, 1'b1);
    wait_valid();
    held_sum = out_sum;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_sum", 32'(out_sum), 32'(held_sum));
    end
    compare_out();
    handshake();
    check("in_ready_after_hs", 32'(in_ready), 32'd1);

    // Reset during SETTLE drops the transaction
    launch(16'hAAAA, 16'h5555, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
    check("mid_rst_out_cout", 32'(out_cout), 32'd0);
    check("mid_rst_out_mismatch", 32'(out_mismatch), 32'd0);
    check("mid_rst_dut_a", 32'(dut_a), 32'd0);
    check("mid_rst_dut_b", 32'(dut_b), 32'd0);
    check("mid_rst_dut_cin", 32'(dut_cin), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_no_result", 32'(out_valid), 32'd0);
    check("post_rst_err_count", 32'(err_count), 32'd0);

    // Random back-to-back traffic with out_ready held high
    out_ready = 1'b1;
    accepted  = 0;
    delivered = 0;
    cyc       = 0;
    last_del  = -1;
    while (delivered < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        compare_out();
        if (last_del >= 0) check("throughput", 32'(cyc - last_del), 32'(SETTLE + 2));
        last_del = cyc;
        delivered++;
      end
      if (in_ready) begin
        if (accepted < 10000) begin
          in_a     = N'($urandom);
          in_b     = N'($urandom);
          in_cin   = 1'($urandom);
          in_valid = 1'b1;
          sb.push_back(model(in_a, in_b, in_cin, 1'b0));
          accepted++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("random_delivered", 32'(delivered), 32'd10000);
    check("random_err_count", 32'(err_count), 32'd0);

    // en dropped mid-transaction: in-flight result still delivered, no new accepts
    @(negedge clk);
    in_a     = 16'h8000;
    in_b     = 16'h8000;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    sb.push_back(model(in_a, in_b, in_cin, 1'b0));
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    wait_valid();
    compare_out();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("en_low_in_ready", 32'(in_ready), 32'd0);
    end
    check("en_low_no_result", 32'(out_valid), 32'd0);
    check("en_low_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_launch_capture.md
# adder_launch_capture

Sequential launch/capture stage that wraps any combinational `N`-bit adder under test, such as `carrySkip`. It sits directly upstream and downstream of the adder. It accepts operands over a valid/ready handshake and drives them, registered, onto the adder inputs. It then waits a programmable number of settle cycles, captures `Sout`/`Cout`, checks them against a behavioural `A+B+Cin`, and presents the result over a valid/ready output with error statistics. It replaces the fixed-delay waits in the adder benches and is the register boundary for adder timing runs.

## Interface
Parameters:
- `N`, 16, operand/sum width; must match the DUT's `N`.
- `SETTLE`, 3, clock cycles between operand launch and result capture; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `en`  in  1  enables acceptance of new operands.
- `err_clr`  in  1  synchronous clear of `err_count` and `err_sticky`.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  stage can accept operands.
- `in_a`, `in_b`  in  N  operands.
- `in_cin`  in  1  carry-in.
- `dut_a`, `dut_b`  out  N  registered operands to the adder's `A`/`B`.
- `dut_cin`  out  1  registered carry-in to the adder's `Cin`.
- `dut_sum`  in  N  adder `Sout`.
- `dut_cout`  in  1  adder `Cout`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  N  captured sum.
- `out_cout`  out  1  captured carry-out.
- `out_mismatch`  out  1  captured `{cout,sum}` differs from the reference.
- `err_count`  out  16  saturating mismatch counter.
- `err_sticky`  out  1  set on any mismatch; cleared only by `err_clr` or reset.

## Operation
FSM states: `IDLE`, `SETTLE`, `HOLD`.
- **`IDLE`**
  - `in_ready = en`.
  - On `in_valid && in_ready`, register `in_a`/`in_b`/`in_cin` into `dut_a`/`dut_b`/`dut_cin`, load the settle counter with `SETTLE-1`, and go to `SETTLE`.
- **`SETTLE`**
  - `in_ready = 0`.
  - If the counter is nonzero, decrement it.
  - If the counter is 0, capture `dut_sum`/`dut_cout` into `out_sum`/`out_cout` and compute the reference.
    - The reference is `ref = {1'b0,dut_a} + {1'b0,dut_b} + dut_cin`, evaluated at N+1 bits (no truncation).
    - Set `out_mismatch = ({dut_cout,dut_sum} != ref)`.
    - Go to `HOLD`.
- **`HOLD`**
  - `out_valid = 1`; `in_ready = 0`.
  - On `out_ready`, go to `IDLE`.
  - `out_*` hold their values until the next capture.
- `dut_*` hold the launched operands until the next accept; they are not cleared when a transaction ends.
- **`en` low**
  - Blocks new accepts only.
  - An in-flight transaction completes and is delivered normally.
- **`err_count`**
  - Increments by 1 on each capture with a mismatch.
  - Saturates at 16'hFFFF.
- **`err_sticky`**
  - Set on each capture with a mismatch.
- **`err_clr`**
  - Zeroes `err_count` and `err_sticky`.
  - Has priority over a same-cycle mismatch increment: the result is 0 and 0.

## Timing
- Reset values (`rst_n` low): state `IDLE`, counter 0, `dut_a`/`dut_b` 0, `dut_cin` 0, `out_valid` 0, `out_sum` 0, `out_cout` 0, `out_mismatch` 0, `err_count` 0, `err_sticky` 0.
  - `in_ready` follows `en` combinationally once `rst_n` is high.
- Accept at edge k → `dut_*` valid after edge k → capture at edge k+SETTLE → `out_valid` high from edge k+SETTLE.
- The adder therefore gets exactly SETTLE cycles of combinational settle time.
- Output handshake completes at the first edge with `out_valid && out_ready`; `out_valid` falls after that edge.
- Back-to-back throughput: with `out_ready` tied high, one transaction per SETTLE+2 cycles.
- Reset mid-operation: any state returns to `IDLE` immediately. The in-flight transaction is dropped without being delivered or counted.
- No combinational path from `in_*` to `out_*`. `in_ready` depends only on state and `en`.

## Structure
- Package `adder_tb_pkg`:
  - state enum `alc_state_t` {`IDLE`, `SETTLE`, `HOLD`};
  - `ERR_W = 16`;
  - `SETTLE_W = 8`.
- One sub-module `settle_counter`:
  - down-counter of width `SETTLE_W`;
  - ports `load`, `load_val`, `dec`, `zero`.
- The reference adder stays inline.
- Target size about 200 lines of RTL.

## Test plan
All scenarios use N=16, SETTLE=3 and a correct `carrySkip` unless stated.
1. Accept `in_a`=16'h1234, `in_b`=16'h4321, `in_cin`=0 at edge k → `out_valid` at k+3; `out_sum`=16'h5555, `out_cout`=0, `out_mismatch`=0.
2. `in_a`=16'hFFFF, `in_b`=16'h0001, `in_cin`=0 → `out_sum`=16'h0000, `out_cout`=1, no mismatch. Then 16'hFFFF+16'hFFFF+1 → `out_sum`=16'hFFFF, `out_cout`=1.
3. Faulty model forcing `dut_sum`=0; `in_a`=5, `in_b`=7 → `out_mismatch`=1, `err_count`=1, `err_sticky`=1. Then `err_clr` asserted in the same cycle as a second mismatch capture → `err_count`=0, `err_sticky`=0.
4. `out_ready` held low 10 cycles after `out_valid` → outputs stable, `in_ready`=0 throughout. Raise `out_ready` → `out_valid` drops after one edge, `in_ready`=1 the next cycle.
5. Assert `rst_n` low during `SETTLE` → all outputs at their reset values immediately. No result is delivered and `err_count` is unchanged (0).
6. 10,000 random operand pairs with `out_ready`=1 → zero mismatches, one transaction every 5 cycles. Drop `en` mid-transaction → that transaction is still delivered and no further accepts occur.
